// File: rtl/ifetch_unit.sv
// Instruction fetch unit: PC sequencing, single-outstanding memory requests
// and a show-ahead instruction queue feeding the dispatcher. A redirect
// flushes the queue, drops any returning word and restarts fetch at the target.
module ifetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0040_0000,
  parameter int          QDEPTH   = 4
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] imem_addr,
  output logic        imem_rd_en,
  input  logic [31:0] imem_rdata,
  input  logic        dispatch_ren,
  input  logic        dispatch_jump_branch,
  input  logic [31:0] dispatch_jmp_branch_addr,
  output logic [31:0] ifetch_instruction,
  output logic [31:0] ifetch_pc_plus_four,
  output logic        ifetch_empty_flag
);

  localparam int PTR_W = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  // Queue entry: {instruction word, fetch address + 4}
  logic [63:0]      mem_q [QDEPTH];

  logic [31:0]      pc_q, pc_d;
  logic [31:0]      req_addr_q;
  logic             inflight_q, inflight_d;
  logic [PTR_W-1:0] wptr_q, wptr_d;
  logic [PTR_W-1:0] rptr_q, rptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [CNT_W:0]   occupancy;
  logic             push;
  logic             pop;
  logic             empty;

  // Entries already queued plus the one still in flight must fit the queue,
  // so a returning word always has a slot waiting for it.
  assign occupancy  = {1'b0, cnt_q} + {{CNT_W{1'b0}}, inflight_q};
  assign imem_rd_en = rst & ~dispatch_jump_branch & (occupancy < (CNT_W+1)'(QDEPTH));
  assign imem_addr  = pc_q & ~32'h3;

  // A redirect overrides both the write of a returning word and a pop.
  assign empty = (cnt_q == '0);
  assign push  = inflight_q & ~dispatch_jump_branch;
  assign pop   = dispatch_ren & ~empty & ~dispatch_jump_branch;

  assign ifetch_empty_flag   = empty;
  assign ifetch_instruction  = empty ? 32'h0 : mem_q[rptr_q][63:32];
  assign ifetch_pc_plus_four = empty ? 32'h0 : mem_q[rptr_q][31:0];

  // Next-state for PC, inflight flag, pointers and count
  always_comb begin
    pc_d       = pc_q;
    inflight_d = imem_rd_en;
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    cnt_d      = cnt_q;
    if (dispatch_jump_branch) begin
      pc_d   = dispatch_jmp_branch_addr & ~32'h3;
      wptr_d = '0;
      rptr_d = '0;
      cnt_d  = '0;
    end else begin
      if (imem_rd_en) pc_d = pc_q + 32'd4;
      if (push) wptr_d = wptr_q + PTR_W'(1);
      if (pop)  rptr_d = rptr_q + PTR_W'(1);
      if (push && !pop)      cnt_d = cnt_q + CNT_W'(1);
      else if (!push && pop) cnt_d = cnt_q - CNT_W'(1);
    end
  end

  // Control state register with asynchronous active-low reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q       <= RESET_PC;
      inflight_q <= 1'b0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      cnt_q      <= '0;
    end else begin
      pc_q       <= pc_d;
      inflight_q <= inflight_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      cnt_q      <= cnt_d;
    end
  end

  // Request address and queue storage; contents are masked by the empty flag
  always_ff @(posedge clk) begin
    if (imem_rd_en) req_addr_q <= imem_addr;
    if (push) mem_q[wptr_q] <= {imem_rdata, req_addr_q + 32'd4};
  end

endmodule

// File: tb/tb_ifetch_unit.sv
// Directed bench for ifetch_unit: a memory model returns word=address one
// cycle after each request; a monitor checks every popped head entry against
// a queue of hand-computed expectations, while the main sequence checks
// fetch addresses, strobe and empty timing cycle by cycle.
module tb_ifetch_unit;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc4;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] imem_addr;
  logic        imem_rd_en;
  logic [31:0] imem_rdata = 32'h0;
  logic        dispatch_ren;
  logic        dispatch_jump_branch;
  logic [31:0] dispatch_jmp_branch_addr;
  logic [31:0] ifetch_instruction;
  logic [31:0] ifetch_pc_plus_four;
  logic        ifetch_empty_flag;

  int   vectors = 0;
  int   miscompares = 0;
  int   n_pops = 0;
  ent_t exp_q[$];

  ifetch_unit #(.RESET_PC(32'h0040_0000), .QDEPTH(4)) dut (
    .clk                      (clk),
    .rst                      (rst),
    .imem_addr                (imem_addr),
    .imem_rd_en               (imem_rd_en),
    .imem_rdata               (imem_rdata),
    .dispatch_ren             (dispatch_ren),
    .dispatch_jump_branch     (dispatch_jump_branch),
    .dispatch_jmp_branch_addr (dispatch_jmp_branch_addr),
    .ifetch_instruction       (ifetch_instruction),
    .ifetch_pc_plus_four      (ifetch_pc_plus_four),
    .ifetch_empty_flag        (ifetch_empty_flag)
  );

  always #5 clk = ~clk;

  // Memory model: word equals its address, returned the cycle after the request
  always @(posedge clk) begin
    if (imem_rd_en) imem_rdata <= imem_addr;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_exp(input logic [31:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      ent_t e;
      e.instr = base + 32'(4 * i);
      e.pc4   = base + 32'(4 * i + 4);
      exp_q.push_back(e);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every accepted pop must match the next expected entry
  always @(negedge clk) begin
    if (rst && dispatch_ren && !dispatch_jump_branch && !ifetch_empty_flag) begin
      n_pops++;
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL head_unexpected: got instr %h pc4 %h expected no entry", ifetch_instruction,
                 ifetch_pc_plus_four);
      end else begin
        ent_t e;
        e = exp_q.pop_front();
        chk("head_instr", ifetch_instruction, e.instr);
        chk("head_pc4", ifetch_pc_plus_four, e.pc4);
      end
    end
  end

  initial begin
    logic [6:0] rd_tbl;
    logic [6:0] emp_tbl;
    rd_tbl  = 7'b0001111;  // bit i = expected imem_rd_en in cycle i after release
    emp_tbl = 7'b0000011;  // bit i = expected empty flag in cycle i after release
    rst = 1'b0;
    dispatch_ren = 1'b0;
    dispatch_jump_branch = 1'b0;
    dispatch_jmp_branch_addr = 32'h0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_rd_en", 32'(imem_rd_en), 32'h0);
    chk("rst_empty", 32'(ifetch_empty_flag), 32'h1);
    chk("rst_instr", ifetch_instruction, 32'h0);
    chk("rst_pc4", ifetch_pc_plus_four, 32'h0);
    chk("rst_addr", imem_addr, 32'h0040_0000);

    // Warm-up with no pops: four fetches, then the strobe drops
    step();
    rst = 1'b1;
    push_exp(32'h0040_0000, 4);
    for (int i = 0; i < 7; i++) begin
      if (i > 0) step();
      @(negedge clk);
      chk("warm_rd_en", 32'(imem_rd_en), 32'(rd_tbl[i]));
      if (i < 4) chk("warm_addr", imem_addr, 32'h0040_0000 + 32'(4 * i));
      chk("warm_empty", 32'(ifetch_empty_flag), 32'(emp_tbl[i]));
      if (i == 2) begin
        chk("warm_head_instr", ifetch_instruction, 32'h0040_0000);
        chk("warm_head_pc4", ifetch_pc_plus_four, 32'h0040_0004);
      end
    end

    // Streaming: one pop per cycle with no empty bubbles
    step();
    push_exp(32'h0040_0010, 10);
    dispatch_ren = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (i > 0) step();
      @(negedge clk);
      chk("stream_empty", 32'(ifetch_empty_flag), 32'h0);
    end
    step();
    dispatch_ren = 1'b0;
    repeat (4) step();

    // Redirect with three queued entries and one in flight
    step();
    dispatch_ren = 1'b1;
    step();
    dispatch_ren = 1'b0;
    @(negedge clk);
    chk("pre_redir_rd_en", 32'(imem_rd_en), 32'h1);
    chk("pre_redir_addr", imem_addr, 32'h0040_0038);
    step();
    dispatch_jump_branch = 1'b1;
    dispatch_jmp_branch_addr = 32'h0040_0100;
    exp_q.delete();
    @(negedge clk);
    chk("redir_rd_en", 32'(imem_rd_en), 32'h0);
    step();
    dispatch_jump_branch = 1'b0;
    @(negedge clk);
    chk("redir_t1_empty", 32'(ifetch_empty_flag), 32'h1);
    chk("redir_t1_addr", imem_addr, 32'h0040_0100);
    chk("redir_t1_rd_en", 32'(imem_rd_en), 32'h1);
    step();
    @(negedge clk);
    chk("redir_t2_empty", 32'(ifetch_empty_flag), 32'h1);
    step();
    @(negedge clk);
    chk("redir_t3_empty", 32'(ifetch_empty_flag), 32'h0);
    chk("redir_t3_instr", ifetch_instruction, 32'h0040_0100);
    chk("redir_t3_pc4", ifetch_pc_plus_four, 32'h0040_0104);

    // Redirect, pop and pending push together; target has low bits set
    step();
    dispatch_jump_branch = 1'b1;
    dispatch_ren = 1'b1;
    dispatch_jmp_branch_addr = 32'h0040_0203;
    exp_q.delete();
    push_exp(32'h0040_0200, 10);
    step();
    dispatch_jump_branch = 1'b0;
    dispatch_ren = 1'b0;
    @(negedge clk);
    chk("combo_t1_empty", 32'(ifetch_empty_flag), 32'h1);
    chk("combo_t1_rd_en", 32'(imem_rd_en), 32'h1);
    chk("combo_t1_addr", imem_addr, 32'h0040_0200);
    step();
    @(negedge clk);
    chk("combo_t2_empty", 32'(ifetch_empty_flag), 32'h1);
    chk("combo_t2_addr", imem_addr, 32'h0040_0204);
    step();
    dispatch_ren = 1'b1;
    @(negedge clk);
    chk("combo_t3_empty", 32'(ifetch_empty_flag), 32'h0);
    repeat (7) step();
    step();
    dispatch_ren = 1'b0;
    repeat (3) step();

    // Asynchronous reset between edges clears outputs immediately
    @(posedge clk);
    #3;
    rst = 1'b0;
    exp_q.delete();
    #1;
    chk("async_rd_en", 32'(imem_rd_en), 32'h0);
    chk("async_empty", 32'(ifetch_empty_flag), 32'h1);
    chk("async_instr", ifetch_instruction, 32'h0);
    chk("async_pc4", ifetch_pc_plus_four, 32'h0);
    chk("async_addr", imem_addr, 32'h0040_0000);
    step();
    step();

    // Restart after release; pops while empty are ignored
    @(posedge clk);
    #1;
    rst = 1'b1;
    dispatch_ren = 1'b1;
    push_exp(32'h0040_0000, 9);
    @(negedge clk);
    chk("restart_rd_en", 32'(imem_rd_en), 32'h1);
    chk("restart_addr", imem_addr, 32'h0040_0000);
    chk("eren_empty0", 32'(ifetch_empty_flag), 32'h1);
    chk("eren_instr0", ifetch_instruction, 32'h0);
    chk("eren_pc4_0", ifetch_pc_plus_four, 32'h0);
    step();
    @(negedge clk);
    chk("eren_empty1", 32'(ifetch_empty_flag), 32'h1);
    chk("eren_instr1", ifetch_instruction, 32'h0);
    chk("eren_pc4_1", ifetch_pc_plus_four, 32'h0);
    chk("restart_addr1", imem_addr, 32'h0040_0004);
    step();
    @(negedge clk);
    chk("restart_empty2", 32'(ifetch_empty_flag), 32'h0);
    chk("restart_pc4", ifetch_pc_plus_four, 32'h0040_0004);
    repeat (5) step();
    step();
    dispatch_ren = 1'b0;
    repeat (2) step();

    // Total accepted pops: 10 streaming + 1 pre-redirect + 8 + 6
    chk("pop_count", 32'(n_pops), 32'd25);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ifetch_unit.md
IFETCH_UNIT -- requirements
Module: ifetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0040_0000: first fetch address after reset.
REQ-002 Parameter QDEPTH, default 4: instruction-queue entries, power of two, at least 2.
REQ-003 clk  input  1  sole clock, rising-edge active.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 imem_addr  output  32  fetch address.
REQ-006 imem_rd_en  output  1  fetch request strobe.
REQ-007 imem_rdata  input  32  instruction word, valid exactly one cycle after the cycle in which imem_rd_en=1.
REQ-008 dispatch_ren  input  1  dispatcher pops the queue head.
REQ-009 dispatch_jump_branch  input  1  redirect request from the dispatcher.
REQ-010 dispatch_jmp_branch_addr  input  32  redirect target.
REQ-011 ifetch_instruction  output  32  instruction word at the queue head.
REQ-012 ifetch_pc_plus_four  output  32  fetch address of the head entry plus 4.
REQ-013 ifetch_empty_flag  output  1  queue empty.

Function
REQ-014 The block SHALL hold a PC register; imem_addr SHALL equal the PC with bits [1:0] forced to 0.
REQ-015 imem_rd_en SHALL equal: rst high, dispatch_jump_branch low, and (queue count + inflight) < QDEPTH.
REQ-016 On each edge with imem_rd_en=1: the PC SHALL advance by 4 (modulo 2^32; 0xFFFFFFFC wraps to 0); inflight SHALL be set; the issued address SHALL be saved in a request register.
REQ-017 On the edge following an issue: {imem_rdata, saved address+4} SHALL be written at the queue tail and inflight SHALL be cleared, unless the write is discarded per REQ-021.
REQ-018 The queue SHALL be show-ahead.
  - Head outputs are valid combinationally whenever ifetch_empty_flag=0.
  - When the queue is empty, ifetch_instruction and ifetch_pc_plus_four SHALL be 32'h0.
  - A written entry becomes visible the cycle after the write (no bypass).
  - Latency from an issue with an empty queue to ifetch_empty_flag low SHALL be 2 cycles.
REQ-019 A pop SHALL occur on an edge where dispatch_ren=1 and the queue is not empty.
  - dispatch_ren with an empty queue SHALL be ignored; no underflow and no state change.
REQ-020 Push and pop on the same edge SHALL leave the count unchanged.
  - Sustained throughput SHALL be 1 instruction per cycle when the dispatcher pops every cycle.
REQ-021 Redirect, on an edge where dispatch_jump_branch=1:
  - queue pointers and count SHALL be cleared;
  - PC SHALL load the redirect address with bits [1:0] forced to 0;
  - any returning imem_rdata SHALL be discarded;
  - inflight SHALL be cleared.
REQ-022 Redirect SHALL take priority over a simultaneous pop and a simultaneous push.
REQ-023 Redirect timing, with redirect asserted in cycle t:
  - the target fetch SHALL issue in cycle t+1;
  - the target entry SHALL be at the head in cycle t+3;
  - no pre-redirect instruction SHALL ever appear at the head after cycle t.
REQ-024 Pointers SHALL be log2(QDEPTH) bits and wrap; the count SHALL be log2(QDEPTH)+1 bits; the queue SHALL never exceed QDEPTH entries.

Reset
REQ-025 While rst is low, the block SHALL immediately (asynchronously) set:
  - PC to RESET_PC;
  - count, pointers and inflight to 0;
  - imem_rd_en to 0;
  - ifetch_empty_flag to 1;
  - ifetch_instruction and ifetch_pc_plus_four to 0.
REQ-026 Reset asserted mid-operation SHALL discard all queued and inflight instructions.
REQ-027 The first fetch SHALL issue in the first cycle after rst deasserts, at address RESET_PC.

Verification
REQ-028 Release reset, with memory returning word=address, and no pops:
  - fetches 0x00400000, 0x00400004, 0x00400008 and 0x0040000C are issued;
  - imem_rd_en then stays low;
  - the head shows instruction 0x00400000 with pc_plus_four 0x00400004, empty falling 2 cycles after the first fetch.
REQ-029 dispatch_ren held high after warm-up:
  - one pop per cycle;
  - pc_plus_four increments by 4 every cycle;
  - no empty bubbles.
REQ-030 With 3 entries queued plus one inflight, redirect to 0x00400100:
  - empty=1 the next cycle, with imem_addr=0x00400100;
  - pc_plus_four=0x00400104 at the head in cycle t+3;
  - no stale word is ever observed at the head.
REQ-031 Redirect and dispatch_ren in the same cycle, with a push also pending:
  - the queue is empty afterwards;
  - exactly one target fetch follows.
REQ-032 dispatch_ren pulsed while empty: count stays 0 and the head outputs stay 32'h0.
REQ-033 rst driven low between clock edges mid-stream:
  - outputs clear before the next edge;
  - after release, the fetch restarts at 0x00400000.
